// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus receiver.
package lcd_pkg;

   typedef enum logic [1:0] {S_8BIT, S_HI, S_LO} state_t;

   // Command class masks; the highest set bit selects the command.
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam logic [7:0] CMD_ENTRY = 8'h04;
   localparam logic [7:0] CMD_DISP  = 8'h08;
   localparam logic [7:0] CMD_SHIFT = 8'h10;
   localparam logic [7:0] CMD_FUNC  = 8'h20;
   localparam logic [7:0] CMD_CGRAM = 8'h40;
   localparam logic [7:0] CMD_DDRAM = 8'h80;

   // Visible DDRAM window of a 2x16 panel.
   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE_LEN   = 7'd16;

   // Map an address counter value to {hit, buffer index}; hit=0 when off-screen.
   function automatic logic [5:0] ac_to_index(input logic [6:0] ac);
      logic [6:0] off1;
      logic [6:0] off2;
      off1 = ac - LINE1_BASE;
      off2 = ac - LINE2_BASE;
      if (off1 < LINE_LEN)      return {2'b10, off1[3:0]};
      else if (off2 < LINE_LEN) return {2'b11, off2[3:0]};
      else                      return 6'b0;
   endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 mirror of the visible DDRAM: one write port, one registered read port.
module lcd_ddram (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [32];

   // Storage write; contents are initialised by the clear sweep, not by reset.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Registered read; a colliding write is seen one cycle later (read-old).
   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiving end of the 4-bit LCD bus: strobe detection, nibble assembly,
// command/data decode and a DDRAM mirror with a clear sweep.
module lcd_bus_receiver
   import lcd_pkg::*;
#(
   parameter int         MIN_E_HIGH = 8,
   parameter int         CNT_W      = 8,
   parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
   input  logic       qzt_clk,
   input  logic       rst,
   input  logic [1:0] lcd_flags,
   input  logic [3:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       byte_valid,
   output logic       byte_is_data,
   output logic [7:0] byte_value,
   output logic       mode_4bit,
   output logic       display_on,
   output logic [6:0] cursor_addr,
   output logic       busy,
   output logic       proto_err
);

   localparam logic [CNT_W-1:0] MIN_CNT = MIN_E_HIGH[CNT_W-1:0];

   logic             e_q, rs_q;
   logic [3:0]       d_q;
   logic [CNT_W-1:0] e_cnt;
   state_t           state;
   logic [3:0]       hi_nib;
   logic             hi_rs;
   logic             inc_dec;
   logic [4:0]       sweep_idx;

   logic       strobe, short_pulse, good;
   logic       done, mismatch, apply;
   logic [7:0] cur_byte;
   logic [5:0] ac_map;
   logic       we;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;

   // E falls: e_q still holds the high level, the live input is already low.
   assign strobe      = e_q & ~lcd_flags[0];
   assign short_pulse = e_cnt < MIN_CNT;
   assign good        = strobe & ~short_pulse;
   assign apply       = done & ~busy;
   assign ac_map      = ac_to_index(cursor_addr);

   // Byte assembly for the current strobe; RS/data come from the sampled bus.
   always_comb begin
      done     = 1'b0;
      mismatch = 1'b0;
      cur_byte = {d_q, 4'h0};
      if (good) begin
         case (state)
            S_8BIT: done = 1'b1;
            S_LO: begin
               cur_byte = {hi_nib, d_q};
               if (rs_q != hi_rs) mismatch = 1'b1;
               else               done     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // DDRAM write port: the clear sweep owns the port while busy.
   always_comb begin
      we      = 1'b0;
      wr_addr = ac_map[4:0];
      wr_data = cur_byte;
      if (busy) begin
         we      = 1'b1;
         wr_addr = sweep_idx;
         wr_data = CLEAR_CHAR;
      end else if (apply && rs_q && ac_map[5]) begin
         we = 1'b1;
      end
   end

   // Bus sampling, E-width counter, framing FSM, decode and clear sweep.
   always_ff @(posedge qzt_clk) begin
      if (rst) begin
         e_q          <= 1'b0;
         rs_q         <= 1'b0;
         d_q          <= '0;
         e_cnt        <= '0;
         state        <= S_8BIT;
         hi_nib       <= '0;
         hi_rs        <= 1'b0;
         inc_dec      <= 1'b1;
         byte_valid   <= 1'b0;
         byte_is_data <= 1'b0;
         byte_value   <= '0;
         mode_4bit    <= 1'b0;
         display_on   <= 1'b0;
         cursor_addr  <= '0;
         proto_err    <= 1'b0;
         busy         <= 1'b1;
         sweep_idx    <= '0;
      end else begin
         e_q   <= lcd_flags[0];
         rs_q  <= lcd_flags[1];
         d_q   <= lcd_data;
         e_cnt <= !lcd_flags[0]            ? '0 :
                  (e_cnt == {CNT_W{1'b1}}) ? e_cnt : e_cnt + 1'b1;

         byte_valid <= done;
         if (done) begin
            byte_value   <= cur_byte;
            byte_is_data <= rs_q;
         end
         if ((strobe && short_pulse) || mismatch || (done && busy))
            proto_err <= 1'b1;

         if (busy) begin
            sweep_idx <= sweep_idx + 5'd1;
            if (sweep_idx == 5'd31) busy <= 1'b0;
         end

         if (good) begin
            case (state)
               S_8BIT: if (d_q == 4'h2) begin
                  state     <= S_HI;
                  mode_4bit <= 1'b1;
               end
               S_HI: begin
                  hi_nib <= d_q;
                  hi_rs  <= rs_q;
                  state  <= S_LO;
               end
               default: state <= S_HI;
            endcase
         end

         // Decode; later assignments here override the framing above.
         if (apply) begin
            if (rs_q)
               cursor_addr <= inc_dec ? cursor_addr + 7'd1 : cursor_addr - 7'd1;
            else if (|(cur_byte & CMD_DDRAM))
               cursor_addr <= cur_byte[6:0];
            else if (|(cur_byte & CMD_CGRAM)) begin
            end else if (|(cur_byte & CMD_FUNC)) begin
               if (cur_byte[4]) begin
                  mode_4bit <= 1'b0;
                  state     <= S_8BIT;
               end
            end else if (|(cur_byte & CMD_SHIFT)) begin
            end else if (|(cur_byte & CMD_DISP))
               display_on <= cur_byte[2];
            else if (|(cur_byte & CMD_ENTRY))
               inc_dec <= cur_byte[1];
            else if (|(cur_byte & CMD_HOME))
               cursor_addr <= '0;
            else if (|(cur_byte & CMD_CLEAR)) begin
               cursor_addr <= '0;
               busy        <= 1'b1;
               sweep_idx   <= '0;
            end
         end
      end
   end

   lcd_ddram u_ddram (
      .clk     (qzt_clk),
      .rst     (rst),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: init sequence, DDRAM writes, errors, reset.
module tb_lcd_bus_receiver;

   logic       qzt_clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] lcd_flags = 2'b00;
   logic [3:0] lcd_data = 4'h0;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_data;
   logic       byte_valid, byte_is_data;
   logic [7:0] byte_value;
   logic       mode_4bit, display_on, busy, proto_err;
   logic [6:0] cursor_addr;

   int errors = 0;
   int checks = 0;
   int bv_cnt = 0;
   logic [7:0] last_val = 8'h00;
   logic       last_data = 1'b0;

   always #5 qzt_clk = ~qzt_clk;

   lcd_bus_receiver dut (
      .qzt_clk      (qzt_clk),
      .rst          (rst),
      .lcd_flags    (lcd_flags),
      .lcd_data     (lcd_data),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .byte_valid   (byte_valid),
      .byte_is_data (byte_is_data),
      .byte_value   (byte_value),
      .mode_4bit    (mode_4bit),
      .display_on   (display_on),
      .cursor_addr  (cursor_addr),
      .busy         (busy),
      .proto_err    (proto_err)
   );

   // Record every completed byte.
   always @(negedge qzt_clk) begin
      if (byte_valid === 1'b1) begin
         bv_cnt    = bv_cnt + 1;
         last_val  = byte_value;
         last_data = byte_is_data;
      end
   end

   task automatic send_nibble(input logic rs, input logic [3:0] nib, input int w);
      @(negedge qzt_clk);
      lcd_flags = {rs, 1'b1};
      lcd_data  = nib;
      repeat (w) @(negedge qzt_clk);
      lcd_flags = {rs, 1'b0};
      repeat (4) @(negedge qzt_clk);
      lcd_flags = 2'b00;
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] b);
      send_nibble(rs, b[7:4], 16);
      send_nibble(rs, b[3:0], 16);
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] d);
      @(negedge qzt_clk);
      rd_addr = a;
      @(negedge qzt_clk);
      d = rd_data;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge qzt_clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic test_reset(input string tag);
      int n = 0;
      @(negedge qzt_clk);
      rst = 1'b1;
      lcd_flags = 2'b00;
      repeat (3) @(negedge qzt_clk);
      rst = 1'b0;
      checks++;
      if ({rd_data, byte_valid, byte_is_data, byte_value, mode_4bit, display_on,
           cursor_addr, proto_err} !== 28'd0) begin
         errors++;
         $display("FAIL %s reset_outputs: rd=%h bv=%b bd=%b val=%h m4=%b don=%b ac=%h err=%b, required all 0",
                  tag, rd_data, byte_valid, byte_is_data, byte_value, mode_4bit, display_on,
                  cursor_addr, proto_err);
      end
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge qzt_clk);
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL %s reset_busy_len: got %0d cycles, required 32", tag, n);
      end
   endtask

   task automatic test_power_on();
      logic [3:0] nibs [4];
      int c;
      nibs[0] = 4'h3; nibs[1] = 4'h3; nibs[2] = 4'h3; nibs[3] = 4'h2;
      for (int i = 0; i < 4; i++) begin
         c = bv_cnt;
         send_nibble(1'b0, nibs[i], 16);
         checks++;
         if (bv_cnt != c + 1 || last_val !== {nibs[i], 4'h0}) begin
            errors++;
            $display("FAIL power_on_byte%0d: count=%0d val=%h, required count=%0d val=%h",
                     i, bv_cnt - c, last_val, 1, {nibs[i], 4'h0});
         end
         checks++;
         if (mode_4bit !== (i == 3)) begin
            errors++;
            $display("FAIL power_on_mode%0d: mode_4bit=%b, required %b", i, mode_4bit, (i == 3));
         end
      end
   endtask

   task automatic test_init_4bit();
      logic [7:0] cmds [4];
      logic [7:0] d;
      cmds[0] = 8'h28; cmds[1] = 8'h06; cmds[2] = 8'h0C; cmds[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
         send_byte(1'b0, cmds[i]);
         checks++;
         if (last_val !== cmds[i] || last_data !== 1'b0) begin
            errors++;
            $display("FAIL init_byte%0d: val=%h rs=%b, required %h rs=0", i, last_val, last_data, cmds[i]);
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL init_clear_busy: busy=%b, required 1", busy);
      end
      checks++;
      if (display_on !== 1'b1) begin
         errors++;
         $display("FAIL init_display_on: %b, required 1", display_on);
      end
      wait_idle();
      checks++;
      if (cursor_addr !== 7'h00) begin
         errors++;
         $display("FAIL init_cursor: %h, required 00", cursor_addr);
      end
      for (int a = 0; a < 32; a++) begin
         rd(a[4:0], d);
         checks++;
         if (d !== 8'h20) begin
            errors++;
            $display("FAIL init_ddram[%0d]: %h, required 20", a, d);
         end
      end
   endtask

   task automatic test_data_write();
      logic [7:0] d;
      send_byte(1'b0, 8'h80);
      send_byte(1'b1, 8'h41);
      send_byte(1'b1, 8'h35);
      rd(5'd0, d);
      checks++;
      if (d !== 8'h41) begin errors++; $display("FAIL data_idx0: %h, required 41", d); end
      rd(5'd1, d);
      checks++;
      if (d !== 8'h35) begin errors++; $display("FAIL data_idx1: %h, required 35", d); end
      checks++;
      if (cursor_addr !== 7'h02) begin errors++; $display("FAIL data_cursor: %h, required 02", cursor_addr); end
      checks++;
      if (last_data !== 1'b1 || byte_is_data !== 1'b1 || last_val !== 8'h35) begin
         errors++;
         $display("FAIL data_is_data: rs=%b val=%h, required rs=1 val=35", last_data, last_val);
      end
   endtask

   task automatic test_line2_edge();
      logic [7:0] d;
      send_byte(1'b0, 8'hCF);
      send_byte(1'b1, 8'h42);
      send_byte(1'b1, 8'h43);
      rd(5'd31, d);
      checks++;
      if (d !== 8'h42) begin errors++; $display("FAIL line2_idx31: %h, required 42", d); end
      rd(5'd16, d);
      checks++;
      if (d !== 8'h20) begin errors++; $display("FAIL line2_idx16: %h, required 20", d); end
      rd(5'd0, d);
      checks++;
      if (d !== 8'h41) begin errors++; $display("FAIL line2_idx0: %h, required 41", d); end
      checks++;
      if (cursor_addr !== 7'h51) begin errors++; $display("FAIL line2_cursor: %h, required 51", cursor_addr); end
   endtask

   task automatic test_short_pulse();
      int c;
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL short_pre_err: %b, required 0", proto_err); end
      c = bv_cnt;
      send_nibble(1'b0, 4'h1, 4);
      checks++;
      if (bv_cnt != c) begin errors++; $display("FAIL short_no_byte: %0d bytes, required 0", bv_cnt - c); end
      checks++;
      if (proto_err !== 1'b1) begin errors++; $display("FAIL short_err: %b, required 1", proto_err); end
      send_byte(1'b0, 8'h08);
      checks++;
      if (last_val !== 8'h08 || display_on !== 1'b0) begin
         errors++;
         $display("FAIL short_state_kept: val=%h don=%b, required 08 don=0", last_val, display_on);
      end
   endtask

   task automatic test_reset_mid_byte();
      int c;
      send_nibble(1'b0, 4'h8, 16);
      test_reset("mid_byte");
      c = bv_cnt;
      send_nibble(1'b0, 4'h3, 16);
      checks++;
      if (bv_cnt != c + 1 || last_val !== 8'h30 || mode_4bit !== 1'b0) begin
         errors++;
         $display("FAIL mid_byte_8bit: count=%0d val=%h m4=%b, required 1 30 0", bv_cnt - c, last_val, mode_4bit);
      end
   endtask

   task automatic test_rs_mismatch();
      int c;
      c = bv_cnt;
      send_nibble(1'b0, 4'h2, 8);
      checks++;
      if (bv_cnt != c + 1 || mode_4bit !== 1'b1 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL min_width: count=%0d m4=%b err=%b, required 1 1 0", bv_cnt - c, mode_4bit, proto_err);
      end
      c = bv_cnt;
      send_nibble(1'b0, 4'h4, 16);
      send_nibble(1'b1, 4'h1, 16);
      checks++;
      if (bv_cnt != c || proto_err !== 1'b1) begin
         errors++;
         $display("FAIL rs_mismatch: count=%0d err=%b, required 0 1", bv_cnt - c, proto_err);
      end
      send_byte(1'b0, 8'h0C);
      checks++;
      if (last_val !== 8'h0C || display_on !== 1'b1) begin
         errors++;
         $display("FAIL mismatch_resync: val=%h don=%b, required 0C 1", last_val, display_on);
      end
   endtask

   task automatic test_clear_again();
      logic [7:0] d;
      send_byte(1'b0, 8'h80);
      send_byte(1'b1, 8'h5A);
      rd(5'd0, d);
      checks++;
      if (d !== 8'h5A) begin errors++; $display("FAIL clr_pre: %h, required 5A", d); end
      send_byte(1'b0, 8'h01);
      wait_idle();
      rd(5'd0, d);
      checks++;
      if (d !== 8'h20 || cursor_addr !== 7'h00) begin
         errors++;
         $display("FAIL clr_post: idx0=%h ac=%h, required 20 00", d, cursor_addr);
      end
   endtask

   initial begin
      test_reset("power_on");
      test_power_on();
      test_init_4bit();
      test_data_write();
      test_line2_edge();
      test_short_pulse();
      test_reset_mid_byte();
      test_rs_mismatch();
      test_clear_again();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
